keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Consumes the one-cycle key event pulses produced by the key pulse generator and assembles multi-digit decimal entries. Supports digit shift-in, backspace, clear and enter. Presents the completed packed-BCD value to downstream logic over a valid/ready handshake. Sits between the keypad pulse stage and any consumer of operator-entered numbers.

Parameters:
NUM_DIGITS, 4, maximum digits held; value width is 4*NUM_DIGITS.
TIMEOUT_CYCLES, 1000, idle cycles in ENTRY before auto-clear; used only with KEY_TIMEOUT_EN.

Ports:
newClock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
keyPulse  input  5  key event: [4] strobe, [3:0] key code; code valid only while [4]=1.
out_ready  input  1  downstream accepts bcd_value this cycle.
bcd_value  output  4*NUM_DIGITS  packed BCD; most recent digit in [3:0].
out_valid  output  1  bcd_value holds a completed entry.
digit_count  output  CW  digits held; CW = ceil(log2(NUM_DIGITS+1)), 3 at default.
overflow  output  1  sticky: a digit was entered while full.
entry_active  output  1  high in ENTRY state.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge newClock): state IDLE; bcd_value=0, out_valid=0, digit_count=0, overflow=0, entry_active=0. Reset mid-entry or mid-handshake discards everything.
- Key decode when keyPulse[4]=1: 0-9 digit; 4'hA clear; 4'hB backspace; 4'hE enter; all other codes ignored. No edge detection: each cycle with strobe high is one event.
- Latency: event sampled at edge k; all outputs reflect it after edge k.
- States: IDLE (count=0), ENTRY (count>0), HOLD (entry presented).
- Digit, count<NUM_DIGITS: bcd_value <= {bcd_value shifted left 4, code}; count+1; IDLE->ENTRY.
- Digit, count=NUM_DIGITS: value and count unchanged; overflow<=1.
- Backspace: count>0 -> bcd_value shifted right 4 with zero fill; count-1; count reaching 0 -> IDLE. Backspace in IDLE ignored.
- Clear in IDLE/ENTRY: bcd_value=0, count=0, overflow=0, -> IDLE.
- Enter: count=0 ignored. count>0 -> out_valid<=1, -> HOLD; value and count frozen.
- HOLD: transfer completes on a cycle with out_valid=1 and out_ready=1. Next edge: out_valid=0, bcd_value=0, count=0, overflow=0, -> IDLE.
- HOLD: digit, backspace and enter are ignored and dropped. Clear abandons the entry: out_valid=0, clear as above, -> IDLE.
- Clear and out_ready in the same HOLD cycle: the transfer wins; the result is identical IDLE.
- out_ready is ignored outside HOLD. bcd_value is stable while out_valid=1.
- entry_active = (state==ENTRY).

Optional Feature:
KEY_TIMEOUT_EN. When defined, an inactivity counter runs in ENTRY. Any strobe resets it to 0. On reaching TIMEOUT_CYCLES-1 with no strobe, the next edge performs a clear and goes to IDLE. The counter is held at 0 outside ENTRY, and HOLD never times out. When not defined, there is no counter and ENTRY persists indefinitely.

Test Plan:
- Reset, then digits 1,2,3 (one cycle each) -> bcd_value=16'h0123, digit_count=3, entry_active=1, out_valid=0.
- Digits 9,8,7,6,5 with NUM_DIGITS=4 -> bcd_value=16'h9876, count=4, overflow=1; clear -> value 0, count 0, overflow 0.
- Digits 4,5, backspace, enter with out_ready=0 for 5 cycles, then 1 -> out_valid=1 holding 16'h0004 throughout; after the ready cycle out_valid=0, value 0, IDLE.
- In HOLD: digit 7 then enter -> value unchanged; clear and out_ready in the same cycle -> single transfer, IDLE.
- Enter in IDLE, backspace in IDLE, code 4'hC, strobe-low with code 4'h3 -> no output change.
- KEY_TIMEOUT_EN, TIMEOUT_CYCLES=8: digit 2 then 7 idle cycles -> cleared to IDLE exactly on the 8th idle edge. A strobe at idle cycle 6 -> no clear.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: builds multi-digit packed-BCD entries from key pulses
// and hands the finished value downstream over a valid/ready handshake.
//
// Ports:
//   newClock     in   system clock, posedge
//   reset        in   synchronous active-high reset
//   keyPulse     in   [4] strobe, [3:0] key code (0-9 digit, A clr, B bksp, E enter)
//   out_ready    in   downstream accepts bcd_value (HOLD only)
//   bcd_value    out  packed BCD, newest digit in [3:0]
//   out_valid    out  bcd_value holds a completed entry
//   digit_count  out  digits currently held
//   overflow     out  sticky: digit entered while full
//   entry_active out  high while an entry is being typed
//
// Optional: define KEY_TIMEOUT_EN to auto-clear an entry after
// TIMEOUT_CYCLES idle cycles.
module keypad_entry_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int VW = 4 * NUM_DIGITS
) (
  input  logic          newClock,
  input  logic          reset,
  input  logic [4:0]    keyPulse,
  input  logic          out_ready,
  output logic [VW-1:0] bcd_value,
  output logic          out_valid,
  output logic [CW-1:0] digit_count,
  output logic          overflow,
  output logic          entry_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [VW-1:0] value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          strobe;
  logic [3:0]    code;
  logic          timeout;

  assign strobe = keyPulse[4];
  assign code   = keyPulse[3:0];

`ifdef KEY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;

  assign timeout = (state_q == ENTRY) && !strobe && (tmr_q == LAST);

  // Any strobe restarts the idle count; it only runs while in ENTRY.
  always_comb begin
    tmr_d = '0;
    if (state_d == ENTRY && state_q == ENTRY && !strobe)
      tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge newClock) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, ENTRY: begin
        if (timeout) begin
          state_d = IDLE;
          value_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (strobe) begin
          if (code <= 4'd9) begin
            if (count_q == FULL) begin
              ovf_d = 1'b1;
            end else begin
              value_d = {value_q[VW-5:0], code};
              count_d = count_q + ONE;
              state_d = ENTRY;
            end
          end else if (code == 4'hA) begin
            state_d = IDLE;
            value_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end else if (code == 4'hB && count_q != '0) begin
            value_d = value_q >> 4;
            count_d = count_q - ONE;
            if (count_q == ONE) state_d = IDLE;
          end else if (code == 4'hE && count_q != '0) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Transfer and clear end the same way, so they share one path.
        if (out_ready || (strobe && code == 4'hA)) begin
          state_d = IDLE;
          value_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        value_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge newClock) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd_value    = value_q;
  assign digit_count  = count_q;
  assign overflow     = ovf_q;
  assign out_valid    = (state_q == HOLD);
  assign entry_active = (state_q == ENTRY);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: random + directed stimulus against a digit-queue
// reference model, checked every cycle on the falling edge.
module tb_keypad_entry_ctrl;

  localparam int N = 4;
  localparam int T = 8;

  logic        newClock = 1'b0;
  logic        reset;
  logic [4:0]  keyPulse;
  logic        out_ready;
  logic [15:0] bcd_value;
  logic        out_valid;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        entry_active;

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  // reference model state
  int dq[$];
  bit m_hold;
  bit m_ovf;
  int m_idle;

  always #5 newClock = ~newClock;

  keypad_entry_ctrl #(
    .NUM_DIGITS(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .newClock(newClock),
    .reset(reset),
    .keyPulse(keyPulse),
    .out_ready(out_ready),
    .bcd_value(bcd_value),
    .out_valid(out_valid),
    .digit_count(digit_count),
    .overflow(overflow),
    .entry_active(entry_active)
  );

  function automatic logic [15:0] m_value();
    int v = 0;
    foreach (dq[i]) v = v * 16 + dq[i];
    return 16'(v);
  endfunction

  function automatic void m_clear();
    dq.delete();
    m_hold = 0;
    m_ovf  = 0;
  endfunction

  function automatic void m_apply(bit rst, bit s, int c, bit r);
    bit was_entry = !m_hold && dq.size() > 0;
    if (rst) begin
      m_clear();
      m_idle = 0;
      return;
    end
    if (m_hold) begin
      if (r || (s && c == 10)) m_clear();
    end else if (s) begin
      if (c <= 9) begin
        if (dq.size() < N) dq.push_back(c);
        else m_ovf = 1;
      end else if (c == 10) begin
        m_clear();
      end else if (c == 11) begin
        if (dq.size() > 0) void'(dq.pop_back());
      end else if (c == 14) begin
        if (dq.size() > 0) m_hold = 1;
      end
    end
`ifdef KEY_TIMEOUT_EN
    if (s || !was_entry) begin
      m_idle = 0;
    end else if (m_idle == T - 1) begin
      m_clear();
      m_idle = 0;
    end else begin
      m_idle++;
    end
    if (m_hold || dq.size() == 0) m_idle = 0;
`else
    if (was_entry) m_idle = 0;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge newClock) begin
    if (run) begin
      chk("value", 32'(bcd_value), 32'(m_value()));
      chk("count", 32'(digit_count), 32'(dq.size()));
      chk("valid", 32'(out_valid), 32'(m_hold));
      chk("ovf", 32'(overflow), 32'(m_ovf));
      chk("active", 32'(entry_active), 32'(!m_hold && dq.size() > 0));
    end
  end

  task automatic step(bit s, logic [3:0] c, bit r, bit rst = 0);
    reset     = rst;
    keyPulse  = {s, c};
    out_ready = r;
    @(posedge newClock);
    m_apply(rst, s, int'(c), r);
    @(negedge newClock);
    #1;
  endtask

  task automatic key(logic [3:0] c);
    step(1, c, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0);
  endtask

  initial begin
    reset = 1; keyPulse = '0; out_ready = 0;
    m_clear();
    m_idle = 0;
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 1);
    run = 1;
    chk("rst_value", 32'(bcd_value), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_active", 32'(entry_active), 32'h0);

    key(4'h1); key(4'h2); key(4'h3);
    chk("d123_value", 32'(bcd_value), 32'h0123);
    chk("d123_count", 32'(digit_count), 32'd3);
    chk("d123_active", 32'(entry_active), 32'd1);
    key(4'hA);

    key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5);
    chk("full_value", 32'(bcd_value), 32'h9876);
    chk("full_count", 32'(digit_count), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    key(4'hA);
    chk("clr_value", 32'(bcd_value), 32'h0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    key(4'h4); key(4'h5); key(4'hB); key(4'hE);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'h0, 0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_value", 32'(bcd_value), 32'h0004);
    end
    step(0, 4'h0, 1);
    chk("xfer_valid", 32'(out_valid), 32'd0);
    chk("xfer_value", 32'(bcd_value), 32'h0);
    chk("xfer_count", 32'(digit_count), 32'd0);

    key(4'h1); key(4'hE); key(4'h7); key(4'hE);
    chk("hold_ign", 32'(bcd_value), 32'h0001);
    step(1, 4'hA, 1);
    chk("clr_xfer_valid", 32'(out_valid), 32'd0);
    chk("clr_xfer_count", 32'(digit_count), 32'd0);

    key(4'hE); key(4'hB); key(4'hC); step(0, 4'h3, 0);
    chk("idle_ign_value", 32'(bcd_value), 32'h0);
    chk("idle_ign_active", 32'(entry_active), 32'd0);

`ifdef KEY_TIMEOUT_EN
    key(4'h2);
    idle(7);
    chk("to_before", 32'(entry_active), 32'd1);
    idle(1);
    chk("to_fire", 32'(entry_active), 32'd0);
    chk("to_count", 32'(digit_count), 32'd0);
    key(4'h2);
    idle(6);
    key(4'hF);
    idle(7);
    chk("to_restart", 32'(entry_active), 32'd1);
    key(4'hA);
`endif

    for (int i = 0; i < 4000; i++) begin
      int sel = $urandom_range(0, 99);
      logic [3:0] c;
      bit s;
      if (sel < 50) c = 4'($urandom_range(0, 9));
      else if (sel < 60) c = 4'hB;
      else if (sel < 66) c = 4'hA;
      else if (sel < 80) c = 4'hE;
      else c = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 99) < ((i / 500) % 2 ? 15 : 60));
      step(s, c, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
